onehot_rr_arbiter: RTL and testbench

//   Round-robin arbiter feeding the one-hot encoder stage: selects one of WIDTH requesters per

---
 rtl/onehot_rr_arbiter_pkg.sv | 20 ++
 rtl/onehot_rr_arbiter_encoder_tree.sv | 85 ++++++++
 rtl/onehot_rr_arbiter.sv | 78 +++++++
 tb/tb_onehot_rr_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/onehot_rr_arbiter_pkg.sv
// Shared types and helpers for the one-hot round-robin arbiter and its encoder tree.
package onehot_rr_arbiter_pkg;

    // Encoder tree implementation styles. They are interchangeable for one-hot inputs.
    typedef enum int unsigned {
        ImplOrMask   = 0,
        ImplPrioLow  = 1,
        ImplPrioHigh = 2,
        ImplTwoLevel = 3,
        ImplSum      = 4
    } enc_impl_e;

    localparam int unsigned NumImpl = 5;

    // Index width that stays at least one bit for degenerate widths.
    function automatic int unsigned idx_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/onehot_rr_arbiter_encoder_tree.sv
// One-hot to binary encoder with selectable implementation; enc_vld flags a non-zero input.
module onehot_encoder_tree
    import onehot_rr_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned SPLIT          = 4,
    parameter int unsigned IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0]               dec_vld,
    output logic                           enc_vld,
    output logic [idx_width(WIDTH)-1:0]    enc_idx
);

    localparam int unsigned WIDTH_LOG = idx_width(WIDTH);
    localparam int unsigned NGRP      = (WIDTH + SPLIT - 1) / SPLIT;

    if (SPLIT < 2 || IMPLEMENTATION >= NumImpl) begin : g_bad_param
        $error("onehot_encoder_tree: unsupported SPLIT or IMPLEMENTATION");
    end

    assign enc_vld = |dec_vld;

    if (IMPLEMENTATION == ImplOrMask) begin : g_or_mask
        always_comb begin
            enc_idx = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (dec_vld[i]) enc_idx = enc_idx | WIDTH_LOG'(i);
            end
        end
    end else if (IMPLEMENTATION == ImplPrioLow) begin : g_prio_low
        always_comb begin
            enc_idx = '0;
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (dec_vld[i]) enc_idx = WIDTH_LOG'(i);
            end
        end
    end else if (IMPLEMENTATION == ImplPrioHigh) begin : g_prio_high
        always_comb begin
            enc_idx = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (dec_vld[i]) enc_idx = WIDTH_LOG'(i);
            end
        end
    end else if (IMPLEMENTATION == ImplTwoLevel) begin : g_two_level
        logic [NGRP-1:0] grp_vld;
        int unsigned     grp_sel;
        int unsigned     loc_sel;

        // Group-level OR picks the active group, then only that group's bits form the offset.
        always_comb begin
            grp_vld = '0;
            grp_sel = 0;
            loc_sel = 0;
            for (int g = 0; g < NGRP; g++) begin
                for (int j = 0; j < SPLIT; j++) begin
                    if (g * SPLIT + j < WIDTH) begin
                        grp_vld[g] = grp_vld[g] | dec_vld[g*SPLIT+j];
                    end
                end
            end
            for (int g = 0; g < NGRP; g++) begin
                if (grp_vld[g]) grp_sel = grp_sel | int'(g);
            end
            for (int g = 0; g < NGRP; g++) begin
                for (int j = 0; j < SPLIT; j++) begin
                    if (g * SPLIT + j < WIDTH && grp_sel == int'(g) && dec_vld[g*SPLIT+j]) begin
                        loc_sel = loc_sel | int'(j);
                    end
                end
            end
            enc_idx = WIDTH_LOG'(grp_sel * SPLIT + loc_sel);
        end
    end else begin : g_sum
        int unsigned acc;

        always_comb begin
            acc = 0;
            for (int i = 0; i < WIDTH; i++) begin
                if (dec_vld[i]) acc = acc + int'(i);
            end
            enc_idx = WIDTH_LOG'(acc);
        end
    end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, valid/ready handshake and encoded index.
module onehot_rr_arbiter
    import onehot_rr_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned SPLIT          = 4,
    parameter int unsigned IMPLEMENTATION = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WIDTH-1:0]               req,
    input  logic                           gnt_rdy,
    output logic [WIDTH-1:0]               gnt,
    output logic                           gnt_vld,
    output logic [idx_width(WIDTH)-1:0]    gnt_idx
);

    localparam int unsigned WIDTH_LOG = idx_width(WIDTH);

    logic [WIDTH-1:0]     gnt_q, gnt_d;
    logic [WIDTH_LOG-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]     sel_oh;
    logic                 load;
    int                   sel_k;

    // Lowest request at or above the pointer; fall back to the lowest request overall.
    function automatic logic [WIDTH-1:0] sel(input logic [WIDTH-1:0]     r,
                                             input logic [WIDTH_LOG-1:0] p);
        logic [WIDTH-1:0] masked;
        logic [WIDTH-1:0] src;
        masked = '0;
        for (int i = 0; i < WIDTH; i++) begin
            masked[i] = r[i] && (i >= int'(p));
        end
        src = (|masked) ? masked : r;
        return src & (~src + WIDTH'(1));
    endfunction

    always_comb begin
        sel_oh = sel(req, ptr_q);
        sel_k  = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sel_oh[i]) sel_k = i;
        end
        load  = !gnt_vld || gnt_rdy;
        gnt_d = gnt_q;
        ptr_d = ptr_q;
        if (load) begin
            gnt_d = sel_oh;
            if (|sel_oh) begin
                ptr_d = (sel_k == int'(WIDTH) - 1) ? '0 : WIDTH_LOG'(sel_k + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q <= '0;
            ptr_q <= '0;
        end else begin
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
        end
    end

    assign gnt = gnt_q;

    onehot_encoder_tree #(
        .WIDTH          (WIDTH),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_enc (
        .dec_vld (gnt_q),
        .enc_vld (gnt_vld),
        .enc_idx (gnt_idx)
    );

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Scoreboard bench: one arbiter per encoder implementation, all driven by the same stimulus.
module tb_onehot_rr_arbiter;

    parameter int unsigned WIDTH = 16;
    parameter int unsigned SPLIT = 4;
    localparam int unsigned IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int          NDUT  = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] req;
    logic             gnt_rdy;
    logic [WIDTH-1:0] gnt_a [NDUT];
    logic             vld_a [NDUT];
    logic [IW-1:0]    idx_a [NDUT];

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;
    int exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        onehot_rr_arbiter #(
            .WIDTH          (WIDTH),
            .SPLIT          (SPLIT),
            .IMPLEMENTATION (g)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .req     (req),
            .gnt_rdy (gnt_rdy),
            .gnt     (gnt_a[g]),
            .gnt_vld (vld_a[g]),
            .gnt_idx (idx_a[g])
        );
    end

    task automatic chk(input string name, input int d, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0h expected %0h", name, d, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] bit_of(input int n);
        return WIDTH'(1) << n;
    endfunction

    function automatic int ref_idx(input logic [WIDTH-1:0] v);
        int r = 0;
        for (int i = WIDTH - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input logic [WIDTH-1:0] g_exp, input bit v_exp);
        for (int d = 0; d < NDUT; d++) begin
            chk({name, "_gnt"}, d, 32'(gnt_a[d]), 32'(g_exp));
            chk({name, "_vld"}, d, 32'(vld_a[d]), 32'(v_exp));
        end
    endtask

    // Monitor: per-cycle invariants plus scoreboard pop on every transfer.
    always @(negedge clk) begin
        if (armed && !rst) begin
            for (int d = 0; d < NDUT; d++) begin
                chk("onehot", d, 32'((gnt_a[d] & (gnt_a[d] - WIDTH'(1))) == '0), 32'(1));
                chk("vld_or", d, 32'(vld_a[d]), 32'(|gnt_a[d]));
                if (vld_a[d]) chk("idx_enc", d, 32'(idx_a[d]), 32'(ref_idx(gnt_a[d])));
            end
            if (vld_a[0] && gnt_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer got idx %0d expected no transfer", idx_a[0]);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    for (int d = 0; d < NDUT; d++) begin
                        chk("xfer_idx", d, 32'(idx_a[d]), 32'(e));
                        chk("xfer_gnt", d, 32'(gnt_a[d]), 32'(bit_of(e)));
                    end
                end
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] ones;
        ones = '1;

        // Reset with all requests asserted.
        rst = 1'b1; req = ones; gnt_rdy = 1'b1;
        step(); step();
        @(negedge clk);
        chk_all("reset", '0, 1'b0);
        armed = 1'b1;
        step();
        rst = 1'b0;

        // Full sweep 0..W-1 then wrap to 0,1.
        for (int i = 0; i < int'(WIDTH); i++) exp_q.push_back(i);
        exp_q.push_back(0);
        exp_q.push_back(1);
        step();
        @(negedge clk);
        chk_all("first_gnt", bit_of(0), 1'b1);
        repeat (WIDTH + 1) step();
        req = '0;
        step();

        // Two requesters at the ends; ptr=2 so the top one goes first.
        req = bit_of(0) | bit_of(WIDTH - 1);
        exp_q.push_back(WIDTH - 1); exp_q.push_back(0);
        exp_q.push_back(WIDTH - 1); exp_q.push_back(0);
        repeat (4) step();
        req = '0;
        step();

        // Stall on grant 3 while req changes underneath.
        req = bit_of(3);
        exp_q.push_back(3);
        step();
        gnt_rdy = 1'b0;
        req = bit_of(4) | bit_of(5) | bit_of(6) | bit_of(7);
        repeat (3) begin
            @(negedge clk);
            chk_all("stall_hold", bit_of(3), 1'b1);
            step();
        end
        gnt_rdy = 1'b1;
        exp_q.push_back(4);
        step();
        @(negedge clk);
        chk_all("after_stall", bit_of(4), 1'b1);
        req = '0;
        step();

        // Grant W-2 leaves ptr=W-1; next pick must wrap to 0.
        req = bit_of(WIDTH - 2);
        exp_q.push_back(WIDTH - 2);
        step();
        req = bit_of(WIDTH - 2) | bit_of(0);
        exp_q.push_back(0);
        exp_q.push_back(WIDTH - 2);
        step(); step();
        req = '0;
        step();

        // Reset while stalled; pointer must return to 0.
        req = bit_of(3);
        step();
        gnt_rdy = 1'b0;
        req = '0;
        @(negedge clk);
        chk_all("stall_pre_rst", bit_of(3), 1'b1);
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        chk_all("rst_in_stall", '0, 1'b0);
        step();
        rst = 1'b0; gnt_rdy = 1'b1; req = ones;
        exp_q.push_back(0);
        step();
        @(negedge clk);
        chk_all("post_rst", bit_of(0), 1'b1);
        req = '0;
        repeat (3) step();

        chk("queue_drained", 0, 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
